// File: rtl/obstacle_pkg.sv
// Shared types and constants for the tree-obstacle scheduler.
package obstacle_pkg;

    // Encoding is visible on the 2-bit state output: 0 = IDLE, 1 = RUN, 2 = HALT.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } obst_state_t;

    // Tree sprite footprint.
    localparam int unsigned SPRITE_W = 15;
    localparam int unsigned SPRITE_H = 8;

    // 8-bit Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3 feed back).
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // One LFSR step: shift left, XOR of the tapped bits enters at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr8.sv
// Free-running pseudo-random source for spawn gaps; steps only when asked.
module lfsr8
    import obstacle_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       advance,
    output logic [7:0] value
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    // Next value: one shift per advance request, otherwise hold.
    always_comb begin
        value_d = value_q;
        if (advance) begin
            value_d = lfsr_next(value_q);
        end
    end

    // LFSR register; never cleared by game restarts, only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= LFSR_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle slot sequencer: spawns, scrolls and retires trees once per frame,
// ramps the scroll speed, and freezes the field on collision.
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter int unsigned NUM_SLOTS         = 3,
    parameter int unsigned SPAWN_X           = 625,
    parameter int unsigned OBST_Y            = 392,
    parameter int unsigned TICK_LINE         = 480,
    parameter int unsigned MIN_GAP           = 96,
    parameter int unsigned SPEED_INIT        = 2,
    parameter int unsigned SPEED_MAX         = 6,
    parameter int unsigned SPEED_STEP_FRAMES = 600
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [9:0]              vcount,
    input  logic                    start,
    input  logic                    collision,
    output logic [NUM_SLOTS-1:0]    slot_en,
    output logic [10*NUM_SLOTS-1:0] slot_posx,
    output logic [10*NUM_SLOTS-1:0] slot_posy,
    output logic [2:0]              speed,
    output logic [1:0]              state,
    output logic                    frame_tick
);

    localparam int unsigned FrameW = $clog2(SPEED_STEP_FRAMES);

    localparam logic [9:0]        TickLine  = 10'(TICK_LINE);
    localparam logic [9:0]        SpawnX    = 10'(SPAWN_X);
    localparam logic [9:0]        ObstY     = 10'(OBST_Y);
    localparam logic [7:0]        MinGap    = 8'(MIN_GAP);
    localparam logic [2:0]        SpeedInit = 3'(SPEED_INIT);
    localparam logic [2:0]        SpeedMax  = 3'(SPEED_MAX);
    localparam logic [FrameW-1:0] FrameLast = FrameW'(SPEED_STEP_FRAMES - 1);

    obst_state_t                 state_q, state_d;
    logic [9:0]                  vcount_q, vcount_d;
    logic [NUM_SLOTS-1:0]        en_q, en_d;
    logic [NUM_SLOTS-1:0][9:0]   posx_q, posx_d;
    logic [2:0]                  speed_q, speed_d;
    logic [7:0]                  gap_q, gap_d;
    logic [7:0]                  next_gap_q, next_gap_d;
    logic [FrameW-1:0]           frame_q, frame_d;
    logic                        frame_tick_q, frame_tick_d;

    logic       tick;
    logic       advance;
    logic       clear_all;
    logic       spawn_done;
    logic [9:0] speed_ext;
    logic [8:0] gap_sum;
    logic [7:0] gap_sat;
    logic [7:0] lfsr_value;
    logic       unused_lfsr_bits;

    // Frame boundary: first cycle of the tick line; an update only lands in RUN
    // when no collision is reported in the same cycle.
    always_comb begin
        vcount_d = vcount;
        tick     = (vcount == TickLine) && (vcount_q != TickLine);
        advance  = (state_q == RUN) && tick && !collision;
    end

    lfsr8 u_lfsr8 (
        .clock   (clock),
        .reset_n (reset_n),
        .advance (advance),
        .value   (lfsr_value)
    );

    // Only the low six bits shape the gap.
    assign unused_lfsr_bits = ^lfsr_value[7:6];

    // Next-state logic: FSM plus the retire/move/gap/spawn/speed pipeline of a frame.
    always_comb begin
        state_d      = state_q;
        en_d         = en_q;
        posx_d       = posx_q;
        speed_d      = speed_q;
        gap_d        = gap_q;
        next_gap_d   = next_gap_q;
        frame_d      = frame_q;
        frame_tick_d = 1'b0;
        clear_all    = 1'b0;
        spawn_done   = 1'b0;

        speed_ext = {7'd0, speed_q};
        gap_sum   = {1'b0, gap_q} + {6'd0, speed_q};
        gap_sat   = gap_sum[8] ? 8'hFF : gap_sum[7:0];

        unique case (state_q)
            IDLE: begin
                clear_all = 1'b1;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Collision beats a same-cycle tick: the frame update is dropped.
                if (collision) begin
                    state_d = HALT;
                end else if (tick) begin
                    frame_tick_d = 1'b1;

                    // Retire trees that would scroll past x = 0, move the rest.
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (en_q[i]) begin
                            if (posx_q[i] < speed_ext) begin
                                en_d[i]   = 1'b0;
                                posx_d[i] = '0;
                            end else begin
                                posx_d[i] = posx_q[i] - speed_ext;
                            end
                        end
                    end

                    gap_d = gap_sat;

                    // Spawn into the lowest free slot; if all are busy the spawn stays
                    // pending because gap_cnt is not cleared.
                    if (gap_sat >= next_gap_q) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (!spawn_done && !en_d[i]) begin
                                en_d[i]    = 1'b1;
                                posx_d[i]  = SpawnX;
                                spawn_done = 1'b1;
                            end
                        end
                    end

                    if (spawn_done) begin
                        gap_d      = '0;
                        next_gap_d = MinGap + {1'b0, lfsr_value[5:0], 1'b0};
                    end

                    // Speed ramp every SPEED_STEP_FRAMES updates, capped.
                    if (frame_q == FrameLast) begin
                        frame_d = '0;
                        if (speed_q < SpeedMax) begin
                            speed_d = speed_q + 3'd1;
                        end
                    end else begin
                        frame_d = frame_q + FrameW'(1);
                    end
                end
            end
            HALT: begin
                if (start) begin
                    clear_all = 1'b1;
                    state_d   = RUN;
                end
            end
            default: begin
                clear_all = 1'b1;
                state_d   = IDLE;
            end
        endcase

        if (clear_all) begin
            en_d       = '0;
            posx_d     = '0;
            speed_d    = SpeedInit;
            gap_d      = '0;
            next_gap_d = MinGap;
            frame_d    = '0;
        end
    end

    // State registers; reset forces every output to its idle value immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            vcount_q     <= '0;
            en_q         <= '0;
            posx_q       <= '0;
            speed_q      <= SpeedInit;
            gap_q        <= '0;
            next_gap_q   <= MinGap;
            frame_q      <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vcount_q     <= vcount_d;
            en_q         <= en_d;
            posx_q       <= posx_d;
            speed_q      <= speed_d;
            gap_q        <= gap_d;
            next_gap_q   <= next_gap_d;
            frame_q      <= frame_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign slot_en    = en_q;
    assign slot_posx  = posx_q;
    assign slot_posy  = {NUM_SLOTS{ObstY}};
    assign speed      = speed_q;
    assign state      = state_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomized scoreboard bench for obstacle_scheduler against a frame-level model.
module tb_obstacle_scheduler;

    localparam int NS = 3;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [9:0]      vcount = '0;
    logic            start = 1'b0;
    logic            collision = 1'b0;
    logic [NS-1:0]   slot_en;
    logic [10*NS-1:0] slot_posx;
    logic [10*NS-1:0] slot_posy;
    logic [2:0]      speed;
    logic [1:0]      state;
    logic            frame_tick;

    obstacle_scheduler dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .vcount     (vcount),
        .start      (start),
        .collision  (collision),
        .slot_en    (slot_en),
        .slot_posx  (slot_posx),
        .slot_posy  (slot_posy),
        .speed      (speed),
        .state      (state),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  en;
        logic [29:0] posx;
        logic [2:0]  speed;
        logic [1:0]  state;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state (game-level view).
    int m_en[NS];
    int m_posx[NS];
    int m_speed, m_gap, m_next_gap, m_lfsr, m_frame, m_state, m_prev_vc, m_ticks;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NS; i++) begin
            m_en[i]   = 0;
            m_posx[i] = 0;
        end
        m_speed    = 2;
        m_gap      = 0;
        m_next_gap = 96;
        m_frame    = 0;
        m_ticks    = 0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_lfsr    = 'hA5;
        m_state   = 0;
        m_prev_vc = 0;
    endfunction

    function automatic void model_tick();
        bit done = 0;
        int fb;
        for (int i = 0; i < NS; i++) begin
            if (m_en[i] != 0) begin
                if (m_posx[i] < m_speed) begin
                    m_en[i]   = 0;
                    m_posx[i] = 0;
                end else begin
                    m_posx[i] -= m_speed;
                end
            end
        end
        m_gap = (m_gap + m_speed > 255) ? 255 : m_gap + m_speed;
        if (m_gap >= m_next_gap) begin
            for (int i = 0; i < NS; i++) begin
                if (!done && m_en[i] == 0) begin
                    m_en[i]   = 1;
                    m_posx[i] = 625;
                    done      = 1;
                end
            end
        end
        if (done) begin
            m_gap      = 0;
            m_next_gap = 96 + 2 * (m_lfsr % 64);
        end
        fb     = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr * 2) % 256) + fb;
        m_frame++;
        if (m_frame == 600) begin
            m_frame = 0;
            if (m_speed < 6) m_speed++;
        end
        m_ticks++;
    endfunction

    function automatic logic [2:0] pack_en();
        logic [2:0] p = '0;
        for (int i = 0; i < NS; i++) p[i] = (m_en[i] != 0);
        return p;
    endfunction

    function automatic logic [29:0] pack_posx();
        logic [29:0] p = '0;
        for (int i = 0; i < NS; i++) p[i*10 +: 10] = 10'(m_posx[i]);
        return p;
    endfunction

    // One clock cycle of stimulus; the model predicts what the edge will do.
    task automatic cycle(input int vc, input bit st, input bit col);
        bit   push = 0;
        bit   tk;
        exp_t e;
        vcount    = 10'(vc);
        start     = st;
        collision = col;
        tk        = (vc == 480) && (m_prev_vc != 480);
        m_prev_vc = vc;
        if (reset_n) begin
            case (m_state)
                0: if (st) begin model_clear(); m_state = 1; end
                1: begin
                    if (col) m_state = 2;
                    else if (tk) begin model_tick(); push = 1; end
                end
                2: if (st) begin model_clear(); m_state = 1; end
                default: ;
            endcase
        end
        e.en    = pack_en();
        e.posx  = pack_posx();
        e.speed = 3'(m_speed);
        e.state = 2'(m_state);
        @(posedge clock);
        if (push) exp_q.push_back(e);
        #1;
    endtask

    // One compressed frame: random lines, one or two cycles on the tick line, then off it.
    task automatic do_frame(input bit rand_start);
        int n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
            int v = $urandom_range(0, 523);
            if (v >= 480) v++;
            cycle(v, rand_start && ($urandom_range(0, 7) == 0), 1'b0);
        end
        n = $urandom_range(1, 2);
        for (int k = 0; k < n; k++) cycle(480, 1'b0, 1'b0);
        cycle(481, 1'b0, 1'b0);
    endtask

    task automatic run_until(input int n, input bit rs);
        int guard = 0;
        while (m_ticks < n && guard < 5000) begin
            do_frame(rs);
            guard++;
        end
    endtask

    // Monitor: every frame_tick pulse must match the next scoreboard entry.
    always @(negedge clock) begin
        if (reset_n) begin
            if (frame_tick) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_tick_unexpected actual=1 required=0");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_en", 32'(slot_en), 32'(mon_e.en));
                    check("sb_posx", 32'(slot_posx), 32'(mon_e.posx));
                    check("sb_speed", 32'(speed), 32'(mon_e.speed));
                    check("sb_state", 32'(state), 32'(mon_e.state));
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL frame_tick_missing actual=0 required=1");
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [29:0] posy_exp;
        posy_exp = {3{10'd392}};
        model_reset();

        // Reset values.
        repeat (3) @(posedge clock);
        #1;
        check("rst_en", 32'(slot_en), 32'd0);
        check("rst_posx", 32'(slot_posx), 32'd0);
        check("rst_posy", 32'(slot_posy), 32'(posy_exp));
        check("rst_speed", 32'(speed), 32'd2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_frame_tick", 32'(frame_tick), 32'd0);
        reset_n = 1'b1;

        // Ticks in IDLE do nothing.
        do_frame(1'b0);
        do_frame(1'b0);
        check("idle_state", 32'(state), 32'd0);
        check("idle_en", 32'(slot_en), 32'd0);

        cycle(10, 1'b1, 1'b0);
        check("start_state", 32'(state), 32'd1);

        // First spawn on tick 48, then 10 ticks of scroll.
        run_until(47, 1'b1);
        check("pre_spawn_en", 32'(slot_en), 32'd0);
        run_until(48, 1'b1);
        check("spawn_en", 32'(slot_en), 32'd1);
        check("spawn_posx", 32'(slot_posx[9:0]), 32'd625);
        run_until(58, 1'b1);
        check("scroll_posx", 32'(slot_posx[9:0]), 32'd605);

        // Speed ramp and saturation.
        run_until(599, 1'b1);
        check("speed_599", 32'(speed), 32'd2);
        run_until(600, 1'b1);
        check("speed_600", 32'(speed), 32'd3);
        run_until(2400, 1'b1);
        check("speed_2400", 32'(speed), 32'd6);
        run_until(3000, 1'b1);
        check("speed_sat", 32'(speed), 32'd6);

        // Collision mid-line freezes the field across frames.
        cycle(100, 1'b0, 1'b1);
        check("halt_state", 32'(state), 32'd2);
        repeat (5) do_frame(1'b0);
        check("halt_en", 32'(slot_en), 32'(pack_en()));
        check("halt_posx", 32'(slot_posx), 32'(pack_posx()));
        check("halt_speed", 32'(speed), 32'd6);

        // Restart from HALT clears everything.
        cycle(200, 1'b1, 1'b0);
        check("restart_state", 32'(state), 32'd1);
        check("restart_en", 32'(slot_en), 32'd0);
        check("restart_posx", 32'(slot_posx), 32'd0);
        check("restart_speed", 32'(speed), 32'd2);
        run_until(150, 1'b1);

        // Collision on the tick cycle discards the update.
        cycle(479, 1'b0, 1'b0);
        cycle(480, 1'b0, 1'b1);
        check("coltick_state", 32'(state), 32'd2);
        check("coltick_posx", 32'(slot_posx), 32'(pack_posx()));
        check("coltick_en", 32'(slot_en), 32'(pack_en()));
        cycle(481, 1'b0, 1'b0);

        // Reset asserted mid-run acts immediately.
        cycle(0, 1'b1, 1'b0);
        run_until(60, 1'b1);
        cycle(5, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_en", 32'(slot_en), 32'd0);
        check("mrst_posx", 32'(slot_posx), 32'd0);
        check("mrst_speed", 32'(speed), 32'd2);
        check("mrst_state", 32'(state), 32'd0);
        check("mrst_frame_tick", 32'(frame_tick), 32'd0);
        model_reset();
        cycle(0, 1'b0, 1'b0);
        reset_n = 1'b1;
        cycle(0, 1'b1, 1'b0);
        run_until(160, 1'b1);

        repeat (3) cycle(481, 1'b0, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
